// File: rtl/fetch_unit_pkg.sv
//----------------------------------------------------------------------------
// Module  : fetch_unit_pkg
// Brief   : Opcode, fetch-state and instruction-field definitions
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam logic [5:0] TY_J = 6'h02;
  localparam logic [5:0] TY_B = 6'h04;

  typedef enum logic [1:0] {
    FS_RST  = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  localparam int c_OPC_HI       = 30;
  localparam int c_OPC_LO       = 25;
  localparam int c_BR_SENSE_BIT = 14;
  localparam int c_IMM14_HI     = 13;
  localparam int c_IMM24_HI     = 23;

  // Offsets are halfword-scaled: sign-extend then shift left by one.
  function automatic logic [31:0] imm14_offset(input logic [13:0] imm);
    return {{17{imm[13]}}, imm, 1'b0};
  endfunction

  function automatic logic [31:0] imm24_offset(input logic [23:0] imm);
    return {{7{imm[23]}}, imm, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//----------------------------------------------------------------------------
// Module  : fetch_unit_if
// Brief   : Instruction-memory and controller-side signals of the fetch stage
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  logic [31:0] im_addr;
  logic        im_read_req;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic [5:0]  opcode;
  logic [4:0]  sub_op_base;
  logic [7:0]  sub_op_ls;
  logic        reg_rt_ra_equal;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] retired_count;

  modport master (
    output im_addr, im_read_req, instr, instr_valid, opcode, sub_op_base,
           sub_op_ls, pc, redirect, retired_count,
    input  im_ready, im_rdata, instr_accept, reg_rt_ra_equal
  );

  modport slave (
    input  im_addr, im_read_req, instr, instr_valid, opcode, sub_op_base,
           sub_op_ls, pc, redirect, retired_count,
    output im_ready, im_rdata, instr_accept, reg_rt_ra_equal
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit_target_gen.sv
//----------------------------------------------------------------------------
// Module  : fetch_target_gen
// Brief   : Next-PC and taken resolution for the instruction held in instr
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module fetch_target_gen
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        reg_rt_ra_equal,
  output logic [31:0] next_pc,
  output logic        taken
);

  logic [5:0] w_opcode;
  logic       w_unused;

  assign w_opcode = instr[c_OPC_HI:c_OPC_LO];
  assign w_unused = instr[31];

  always_comb begin
    taken   = 1'b0;
    next_pc = pc + PC_STEP;
    if (w_opcode == TY_B) begin
      // Sense bit selects BEQ (0) or BNE (1).
      taken = reg_rt_ra_equal ^ instr[c_BR_SENSE_BIT];
      if (taken) begin
        next_pc = pc + imm14_offset(instr[c_IMM14_HI:0]);
      end
    end else if (w_opcode == TY_J) begin
      taken   = 1'b1;
      next_pc = pc + imm24_offset(instr[c_IMM24_HI:0]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//----------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : Single-outstanding instruction fetch with branch/jump redirect
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_retired;
  logic         r_redirect;
  logic         w_accept;
  logic         w_latch;
  logic [31:0]  w_next_pc;
  logic         w_taken;

  fetch_target_gen #(
    .PC_STEP (PC_STEP)
  ) u_target_gen (
    .pc              (r_pc),
    .instr           (r_instr),
    .reg_rt_ra_equal (bus.reg_rt_ra_equal),
    .next_pc         (w_next_pc),
    .taken           (w_taken)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FS_RST;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      FS_RST: w_state_next = FS_REQ;
      FS_REQ: begin
        if (bus.im_ready) begin
          w_latch      = 1'b1;
          w_state_next = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (bus.instr_accept) begin
          w_accept     = 1'b1;
          w_state_next = FS_REQ;
        end
      end
      default: w_state_next = FS_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_retired  <= 32'd0;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= w_accept & w_taken;
      if (w_latch) begin
        r_instr <= bus.im_rdata;
      end
      if (w_accept) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign bus.im_addr       = r_pc;
  assign bus.im_read_req   = (r_state == FS_REQ);
  assign bus.instr         = r_instr;
  assign bus.instr_valid   = (r_state == FS_HOLD);
  assign bus.opcode        = r_instr[c_OPC_HI:c_OPC_LO];
  assign bus.sub_op_base   = r_instr[4:0];
  assign bus.sub_op_ls     = r_instr[7:0];
  assign bus.pc            = r_pc;
  assign bus.redirect      = r_redirect;
  assign bus.retired_count = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//----------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit (vector table + address scoreboard)
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clock;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] mpc;
  logic [31:0] mret;
  int hs_cyc;

  typedef struct {
    logic [31:0] word;
    logic        eq;
    logic [31:0] delta;
    logic        redir;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkb(input logic sense, input logic [13:0] imm);
    return {1'b0, TY_B, 10'd0, sense, imm};
  endfunction

  function automatic logic [31:0] mkj(input logic [23:0] imm);
    return {1'b0, TY_J, 1'b0, imm};
  endfunction

  task automatic wait_req();
    int n = 0;
    while (bus.im_read_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_wait", {31'd0, bus.im_read_req}, 32'd1);
  endtask

  // Entered at a negedge; leaves at the negedge after the data edge (HOLD).
  task automatic fetch(input logic [31:0] word, input int lat, output int req_cycles);
    logic [31:0] exp_addr;
    wait_req();
    req_cycles = 0;
    for (int i = 0; i < lat; i++) begin
      bus.im_ready = 1'b0;
      if (bus.im_read_req === 1'b1) req_cycles++;
      @(negedge clock);
    end
    if (bus.im_read_req === 1'b1) req_cycles++;
    exp_addr = (sb.size() > 0) ? sb.pop_front() : 32'hBAD0_BAD0;
    check("im_addr", bus.im_addr, exp_addr);
    hs_cyc = cyc;
    bus.im_ready = 1'b1;
    bus.im_rdata = word;
    @(posedge clock);
    #1;
    bus.im_ready = 1'b0;
    bus.im_rdata = $urandom;
    @(negedge clock);
    check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("instr", bus.instr, word);
    check("hold_req", {31'd0, bus.im_read_req}, 32'd0);
    check("pc_hold", bus.pc, mpc);
  endtask

  task automatic accept(input logic eq, input logic [31:0] delta, input logic redir,
                        input bit check_drop);
    bus.instr_accept    = 1'b1;
    bus.reg_rt_ra_equal = eq;
    @(posedge clock);
    #1;
    bus.instr_accept    = 1'b0;
    bus.reg_rt_ra_equal = 1'b0;
    mpc  = mpc + delta;
    mret = mret + 32'd1;
    sb.push_back(mpc);
    @(negedge clock);
    check("redirect", {31'd0, bus.redirect}, {31'd0, redir});
    check("retired", bus.retired_count, mret);
    if (check_drop) begin
      @(negedge clock);
      check("redirect_drop", {31'd0, bus.redirect}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc;
    int prev;
    vt[0]  = '{mkj(24'h000078), 1'b0, 32'h0000_00F0, 1'b1};
    vt[1]  = '{mkb(1'b0, 14'h3FFE), 1'b1, 32'hFFFF_FFFC, 1'b1};
    vt[2]  = '{mkj(24'h000002), 1'b0, 32'h0000_0004, 1'b1};
    vt[3]  = '{mkb(1'b0, 14'h3FFE), 1'b0, 32'h0000_0004, 1'b0};
    vt[4]  = '{mkb(1'b1, 14'h3FFE), 1'b0, 32'hFFFF_FFFC, 1'b1};
    vt[5]  = '{mkb(1'b1, 14'h3FFE), 1'b1, 32'h0000_0004, 1'b0};
    vt[6]  = '{{1'b0, 6'h3F, 25'h1FF_FFFF}, 1'b1, 32'h0000_0004, 1'b0};
    vt[7]  = '{mkj(24'hFFFF74), 1'b0, 32'hFFFF_FEE8, 1'b1};
    vt[8]  = '{mkj(24'h000010), 1'b0, 32'h0000_0020, 1'b1};
    vt[9]  = '{mkj(24'hFFFFF6), 1'b1, 32'hFFFF_FFEC, 1'b1};
    vt[10] = '{32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0};

    reset = 1'b0;
    bus.im_ready = 1'b0;
    bus.im_rdata = 32'd0;
    bus.instr_accept = 1'b0;
    bus.reg_rt_ra_equal = 1'b0;
    mpc = 32'd0;
    mret = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_req", {31'd0, bus.im_read_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_retired", bus.retired_count, 32'd0);
    check("rst_redirect", {31'd0, bus.redirect}, 32'd0);

    // Release: first request exactly one clock later, then 0,4,8 every 2 cycles.
    reset = 1'b1;
    sb.push_back(32'd0);
    #1 check("rel_req_low", {31'd0, bus.im_read_req}, 32'd0);
    @(negedge clock);
    check("first_req", {31'd0, bus.im_read_req}, 32'd1);
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0000_0000, 0, rc);
      if (prev >= 0) check("fetch_spacing", hs_cyc - prev, 32'd2);
      prev = hs_cyc;
      accept(1'b0, 32'd4, 1'b0, 1'b0);
    end

    // Memory wait of 3, then hold unaccepted for 5 cycles with stray im_ready.
    fetch(32'h0000_00A5, 3, rc);
    check("req_cycles", rc, 32'd4);
    for (int i = 0; i < 5; i++) begin
      bus.im_ready = 1'b1;
      bus.im_rdata = 32'h1234_5678;
      @(negedge clock);
      check("hold_stable_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("hold_stable_pc", bus.pc, mpc);
      check("hold_stable_instr", bus.instr, 32'h0000_00A5);
      check("hold_stable_ret", bus.retired_count, mret);
    end
    bus.im_ready = 1'b0;
    accept(1'b0, 32'd4, 1'b0, 1'b1);

    for (int i = 0; i < 11; i++) begin
      fetch(vt[i].word, i % 3, rc);
      check("opcode", {26'd0, bus.opcode}, {26'd0, vt[i].word[30:25]});
      check("sub_op_base", {27'd0, bus.sub_op_base}, {27'd0, vt[i].word[4:0]});
      check("sub_op_ls", {24'd0, bus.sub_op_ls}, {24'd0, vt[i].word[7:0]});
      accept(vt[i].eq, vt[i].delta, vt[i].redir, 1'b1);
    end
    check("wrap_pc", mpc, 32'd0);

    // Reset asserted in REQ with im_ready arriving the same cycle.
    wait_req();
    reset = 1'b0;
    bus.im_ready = 1'b1;
    bus.im_rdata = 32'hDEAD_BEEF;
    #1 check("rst_mid_req", {31'd0, bus.im_read_req}, 32'd0);
    repeat (2) @(negedge clock);
    check("rst_mid_instr", bus.instr, 32'd0);
    check("rst_mid_pc", bus.pc, 32'd0);
    check("rst_mid_ret", bus.retired_count, 32'd0);
    check("rst_mid_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_mid_req2", {31'd0, bus.im_read_req}, 32'd0);
    bus.im_ready = 1'b0;
    sb.delete();
    mpc = 32'd0;
    mret = 32'd0;
    sb.push_back(32'd0);
    reset = 1'b1;
    @(negedge clock);

    // instr_accept while requesting must be ignored.
    wait_req();
    bus.instr_accept = 1'b1;
    bus.reg_rt_ra_equal = 1'b1;
    repeat (2) @(negedge clock);
    check("req_acc_pc", bus.pc, 32'd0);
    check("req_acc_ret", bus.retired_count, 32'd0);
    check("req_acc_req", {31'd0, bus.im_read_req}, 32'd1);
    check("req_acc_redir", {31'd0, bus.redirect}, 32'd0);
    bus.instr_accept = 1'b0;
    bus.reg_rt_ra_equal = 1'b0;
    fetch(mkj(24'h000040), 0, rc);
    accept(1'b0, 32'h0000_0080, 1'b1, 1'b1);
    fetch(32'h0000_0000, 1, rc);
    accept(1'b0, 32'd4, 1'b0, 1'b0);
    check("sb_left", sb.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
